// File: rtl/sha1_target_matcher.sv
// Compares a SHA-1 digest stream against a target captured at start.
// Reports the first matching nonce, or exhaustion of the nonce range.
module sha1_target_matcher #(
  parameter int NONCE_W   = 32,
  parameter int CMP_WORDS = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        target0,
  input  logic [31:0]        target1,
  input  logic [31:0]        target2,
  input  logic [31:0]        target3,
  input  logic [31:0]        target4,
  input  logic               start,
  input  logic               abort,
  input  logic               dig_valid,
  input  logic [159:0]       dig_data,
  input  logic [NONCE_W-1:0] dig_nonce,
  input  logic               dig_last,
  output logic               busy,
  output logic               found,
  output logic               exhausted,
  output logic [NONCE_W-1:0] found_nonce,
  output logic [31:0]        checked_count
);

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    FOUND,
    EXHAUSTED
  } state_e;

  state_e             state_q, state_d;
  logic [159:0]       tgt_q, tgt_d;
  logic               s1_valid_q, s1_valid_d;
  logic [4:0]         s1_eq_q, s1_eq_d;
  logic [NONCE_W-1:0] s1_nonce_q, s1_nonce_d;
  logic               s1_last_q, s1_last_d;
  logic [NONCE_W-1:0] found_nonce_q, found_nonce_d;
  logic [31:0]        count_q, count_d;

  logic match;

  assign match = &s1_eq_q;

  // Words beyond CMP_WORDS are treated as always equal.
  always_comb begin
    s1_eq_d = '1;
    for (int i = 0; i < 5; i++) begin
      if (i < CMP_WORDS) begin
        s1_eq_d[i] = (dig_data[159-32*i -: 32] == tgt_q[159-32*i -: 32]);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    tgt_d         = tgt_q;
    s1_valid_d    = dig_valid && (state_q == SEARCH);
    s1_nonce_d    = dig_nonce;
    s1_last_d     = dig_last;
    found_nonce_d = found_nonce_q;
    count_d       = count_q;

    if (s1_valid_q && (state_q == SEARCH)) begin
      if (count_q != 32'hFFFF_FFFF) begin
        count_d = count_q + 32'd1;
      end
      if (match) begin
        found_nonce_d = s1_nonce_q;
        state_d       = FOUND;
      end else if (s1_last_q) begin
        state_d = EXHAUSTED;
      end
    end

    if (abort) begin
      state_d       = IDLE;
      s1_valid_d    = 1'b0;
      found_nonce_d = found_nonce_q;
      count_d       = count_q;
    end else if (start) begin
      state_d       = SEARCH;
      s1_valid_d    = 1'b0;
      tgt_d         = {target0, target1, target2, target3, target4};
      found_nonce_d = '0;
      count_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      tgt_q         <= '0;
      s1_valid_q    <= 1'b0;
      s1_eq_q       <= '0;
      s1_nonce_q    <= '0;
      s1_last_q     <= 1'b0;
      found_nonce_q <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      tgt_q         <= tgt_d;
      s1_valid_q    <= s1_valid_d;
      s1_eq_q       <= s1_eq_d;
      s1_nonce_q    <= s1_nonce_d;
      s1_last_q     <= s1_last_d;
      found_nonce_q <= found_nonce_d;
      count_q       <= count_d;
    end
  end

  assign busy          = (state_q == SEARCH);
  assign found         = (state_q == FOUND);
  assign exhausted     = (state_q == EXHAUSTED);
  assign found_nonce   = found_nonce_q;
  assign checked_count = count_q;

endmodule

// File: doc/sha1_target_matcher.md
Name: sha1_target_matcher

Overview:
- Consumes the five 32-bit target-digest words driven by the HPS-writable PIO output registers (hash0..hash4) and the digest stream from the pipelined SHA-1 core.
- Snapshots the target on start, compares every incoming digest against it, and reports the first matching nonce or exhaustion of the nonce range.
- Results go back to HPS-readable PIO input registers.

Parameters:
- NONCE_W, 32, width of the nonce carried alongside each digest.
- CMP_WORDS, 5, number of most-significant digest words compared (1..5); word 0 = bits 159:128.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- target0  in  32  target digest word 0 (MS), from hash0 PIO out_port
- target1  in  32  target word 1, from hash1 PIO
- target2  in  32  target word 2, from hash2 PIO
- target3  in  32  target word 3, from hash3 PIO
- target4  in  32  target word 4 (LS), from hash4 PIO
- start  in  1  one-cycle pulse: snapshot targets, begin search
- abort  in  1  one-cycle pulse: return to IDLE
- dig_valid  in  1  digest beat valid (no backpressure)
- dig_data  in  160  digest, word 0 in bits 159:128
- dig_nonce  in  NONCE_W  nonce that produced dig_data
- dig_last  in  1  beat carries the final nonce of the range
- busy  out  1  state == SEARCH
- found  out  1  state == FOUND
- exhausted  out  1  state == EXHAUSTED
- found_nonce  out  NONCE_W  nonce of first match
- checked_count  out  32  digests compared since last start

Behaviour:
- Reset (sync, clk edge with reset=1): state IDLE, pipeline valids 0, target snapshot 0, found_nonce 0, checked_count 0; all outputs 0.
- States: IDLE, SEARCH, FOUND, EXHAUSTED.
- start in any state: snapshot target0..4 into internal regs, clear found_nonce and checked_count, flush both pipeline stages, go to SEARCH next cycle.
- abort in any state: flush pipeline, go to IDLE; found_nonce/checked_count hold. abort wins over start in the same cycle.
- Beat accepted only when dig_valid=1 and state==SEARCH in that cycle; the beat in the start cycle is dropped.
- Stage 1 (registered): per-word equality eq[i] = (dig word i == snapshot word i) for i < CMP_WORDS, forced 1 for i >= CMP_WORDS; nonce and last carried alongside.
- Stage 2 (registered decision): match = AND of eq. Latency: beat at cycle N -> found/exhausted visible at N+2.
- checked_count increments by 1 per stage-2 valid entry while SEARCH; saturates at 0xFFFFFFFF.
- Stage-2 valid & match in SEARCH: found_nonce <= nonce, go to FOUND.
- Stage-2 valid & last & !match in SEARCH: go to EXHAUSTED.
- Match and last on the same beat: FOUND.
- In FOUND/EXHAUSTED: in-flight entries discarded, no count, found_nonce frozen (first match only).
- Target inputs changing during SEARCH have no effect until the next start.
- Back-to-back valid beats every cycle supported; no bubbles required.

Test Plan:
- Reset then idle: dig_valid=1 with random data for 10 cycles -> busy=0, checked_count=0, found=0.
- Targets 0x67452301,0xEFCDAB89,0x98BADCFE,0x10325476,0xC3D2E1F0; start; stream 8 beats nonces 0..7, nonce 5 equal to target -> found=1 exactly 2 cycles after nonce-5 beat, found_nonce=5, checked_count=6.
- Same start, no match, dig_last on nonce 99 of 100 beats -> exhausted=1 at beat+2, checked_count=100, found=0.
- CMP_WORDS=1: digest differs only in word 4, word 0 = 0x67452301 -> match reported; CMP_WORDS=5 build -> no match.
- Change target0 to 0xDEADBEEF mid-SEARCH, send digest equal to original snapshot -> found=1 (snapshot used).
- start and abort asserted together during SEARCH -> IDLE next cycle, busy=0; reset asserted mid-SEARCH -> all outputs 0 next cycle.
